// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Ports: clk, rst (sync, active-high), start/funct3/rs1_data/rs2_data/rd_in
//   request, kill flush; busy, done pulse, result, rd_out writeback.
module muldiv_unit #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   funct3,
   input  logic [n-1:0] rs1_data,
   input  logic [n-1:0] rs2_data,
   input  logic [4:0]   rd_in,
   input  logic         kill,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] result,
   output logic [4:0]   rd_out
);

   localparam int CW = $clog2(n) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last_q, last_d;

   logic [2:0]      f_q;
   logic            an_q, bn_q, divz_q;
   logic [n-1:0]    opd_q, a_q;
   logic [2*n-1:0]  acc_q;
   logic [n-1:0]    fin_q, res_q;
   logic [4:0]      rdc_q, rdo_q;

   // operand decode at accept
   logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic [n-1:0]    a_mag, b_mag;

   always_comb begin
      is_div = funct3[2];
      a_sgn  = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
      b_sgn  = is_div ? ~funct3[0] : ~funct3[1];
      a_neg  = a_sgn & rs1_data[n-1];
      b_neg  = b_sgn & rs2_data[n-1];
      a_mag  = a_neg ? -rs1_data : rs1_data;
      b_mag  = b_neg ? -rs2_data : rs2_data;
   end

   // one iteration of each algorithm
   logic [n:0]      mul_sum;
   logic [2*n-1:0]  mul_nxt;
   logic [n:0]      div_hi, div_trial;
   logic [2*n-1:0]  div_nxt;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*n-1:n]}
                + {1'b0, (acc_q[0] ? opd_q : '0)};
      mul_nxt   = {mul_sum, acc_q[n-1:1]};
      // remainder stays below the divisor, so the difference fits n bits
      div_hi    = acc_q[2*n-1:n-1];
      div_trial = div_hi - {1'b0, opd_q};
      div_nxt   = div_trial[n]
                ? {acc_q[2*n-2:0], 1'b0}
                : {div_trial[n-1:0], acc_q[n-2:0], 1'b1};
   end

   // sign fix-up and result select
   logic [2*n-1:0]  prod_s;
   logic [n-1:0]    quot, rem, fin_val;

   always_comb begin
      prod_s  = (an_q ^ bn_q) ? -acc_q : acc_q;
      quot    = (an_q ^ bn_q) ? -acc_q[n-1:0] : acc_q[n-1:0];
      rem     = an_q ? -acc_q[2*n-1:n] : acc_q[2*n-1:n];
      fin_val = '0;
      case (f_q)
         3'b000:  fin_val = prod_s[n-1:0];
         3'b001,
         3'b010,
         3'b011:  fin_val = prod_s[2*n-1:n];
         3'b100,
         3'b101:  fin_val = divz_q ? '1 : quot;
         default: fin_val = divz_q ? a_q : rem;
      endcase
   end

   // control FSM
   logic accept, step, fin, commit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      accept  = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !kill) begin
               accept  = 1'b1;
               state_d = RUN;
               cnt_d   = CW'(n - 1);
               last_d  = 1'b0;
            end
         end
         RUN: begin
            if (kill) begin
               state_d = IDLE;
            end else if (last_q) begin
               // extra edge registers the signed/selected result
               fin     = 1'b1;
               state_d = DONE;
            end else begin
               step = 1'b1;
               if (cnt_q == '0) last_d = 1'b1;
               else             cnt_d  = cnt_q - CW'(1);
            end
         end
         DONE: begin
            commit  = ~kill;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f_q    <= '0;
         an_q   <= 1'b0;
         bn_q   <= 1'b0;
         divz_q <= 1'b0;
         opd_q  <= '0;
         a_q    <= '0;
         acc_q  <= '0;
         fin_q  <= '0;
         res_q  <= '0;
         rdc_q  <= '0;
         rdo_q  <= '0;
      end else begin
         if (accept) begin
            f_q    <= funct3;
            an_q   <= a_neg;
            bn_q   <= b_neg;
            divz_q <= (rs2_data == '0);
            a_q    <= rs1_data;
            opd_q  <= is_div ? b_mag : a_mag;
            acc_q  <= {{n{1'b0}}, (is_div ? a_mag : b_mag)};
            rdc_q  <= rd_in;
         end
         if (step) acc_q <= f_q[2] ? div_nxt : mul_nxt;
         if (fin)  fin_q <= fin_val;
         if (commit) begin
            res_q <= fin_q;
            rdo_q <= rdc_q;
         end
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = done ? fin_q : res_q;
   assign rd_out = done ? rdc_q : rdo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: vector table + scoreboard queue,
// plus reset, kill and start-while-busy sequences.
module tb_muldiv_unit;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst, start, kill;
   logic [2:0]   funct3;
   logic [N-1:0] rs1_data, rs2_data, result;
   logic [4:0]   rd_in, rd_out;
   logic         busy, done;

   muldiv_unit #(.n(N)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
      .kill(kill), .busy(busy), .done(done),
      .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [N-1:0] res;
      logic [4:0]   rd;
   } exp_t;

   typedef struct {
      logic [2:0]   f;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [4:0]   rd;
      logic [N-1:0] res;
   } vec_t;

   exp_t sbq[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [N-1:0] act,
                      input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard consumer
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected done=0");
         end else begin
            mon_e = sbq.pop_front();
            chk("result", result, mon_e.res);
            chk("rd_out", {27'b0, rd_out}, {27'b0, mon_e.rd});
         end
      end
   end

   task automatic issue(input logic [2:0] f, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [4:0] rd);
      @(negedge clk);
      funct3   = f;
      rs1_data = a;
      rs2_data = b;
      rd_in    = rd;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // negedges after the accepting edge until done, -1 on timeout
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   vec_t vecs[$];
   int   lat;
   exp_t e;

   initial begin
      rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0;
      rs1_data = '0; rs2_data = '0; rd_in = '0;

      vecs = '{
         '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB},
         '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE},
         '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000},
         '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF},
         '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD},
         '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF},
         '{3'b101, 32'd100,      32'd7,        5'd7,  32'd14},
         '{3'b111, 32'd100,      32'd7,        5'd8,  32'd2},
         '{3'b101, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF},
         '{3'b111, 32'd5,        32'd0,        5'd10, 32'd5},
         '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000},
         '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h00000000},
         '{3'b100, 32'hFFFFFFF9, 32'd0,        5'd31, 32'hFFFFFFFF},
         '{3'b110, 32'hFFFFFFF9, 32'd0,        5'd30, 32'hFFFFFFF9},
         '{3'b000, 32'd12345,    32'd678,      5'd12, 32'd8369910},
         '{3'b001, 32'h80000000, 32'h80000000, 5'd13, 32'h40000000},
         '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD},
         '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd15, 32'd1}
      };

      // reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd_out", {27'b0, rd_out}, 32'd0);

      // reset mid-RUN: back to idle, no done
      issue(3'b000, 32'd3, 32'd4, 5'd9);
      @(negedge clk);
      chk("run_busy", {31'b0, busy}, 32'd1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_result", result, 32'd0);
      repeat (N + 5) @(negedge clk);

      // vector table
      foreach (vecs[i]) begin
         e.res = vecs[i].res;
         e.rd  = vecs[i].rd;
         issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
         sbq.push_back(e);
         wait_done(lat);
         chk("latency", lat, N + 2);
         if (lat < 0) sbq.delete();
         @(negedge clk);
         chk("hold_result", result, vecs[i].res);
         chk("idle_busy", {31'b0, busy}, 32'd0);
      end

      // start while busy is ignored
      e.res = 32'd42;
      e.rd  = 5'd13;
      issue(3'b000, 32'd6, 32'd7, 5'd13);
      sbq.push_back(e);
      repeat (5) @(negedge clk);
      funct3 = 3'b101; rs1_data = 32'd99; rs2_data = 32'd9;
      rd_in = 5'd20; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat);
      chk("busy_start_done", {31'b0, (lat > 0)}, 32'd1);
      if (lat < 0) sbq.delete();
      repeat (N + 5) @(negedge clk);
      chk("busy_start_idle", {31'b0, busy}, 32'd0);

      // kill in RUN cycle 10
      issue(3'b101, 32'd1000, 32'd3, 5'd12);
      repeat (10) @(negedge clk);
      kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      @(negedge clk);
      chk("kill_busy", {31'b0, busy}, 32'd0);
      chk("kill_result", result, 32'd42);
      chk("kill_rd_out", {27'b0, rd_out}, 32'd13);
      repeat (N + 5) @(negedge clk);

      // kill and start together in idle
      @(negedge clk);
      funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2;
      rd_in = 5'd1; start = 1'b1; kill = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      kill = 1'b0;
      @(negedge clk);
      chk("kill_start_busy", {31'b0, busy}, 32'd0);
      repeat (N + 5) @(negedge clk);
      chk("final_result", result, 32'd42);
      chk("sb_empty", sbq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
